// File: rtl/regfile_scan_checker.sv
// Regfile self-check engine: runs the CPU for a programmed number of cycles while
// tracing regfile writes, then scans every register against an expected-value ROM.
module regfile_scan_checker #(
  parameter int NUM_REGS    = 32,
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 32,
  parameter int CYC_W       = 16,
  parameter int TRACE_DEPTH = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            start_i,
  input  logic                            abort_i,
  input  logic [CYC_W-1:0]                num_cycles_i,
  input  logic                            wr_en_i,
  input  logic [ADDR_W-1:0]               wr_reg_i,
  input  logic [DATA_W-1:0]               wr_data_i,
  output logic                            test_mode_o,
  output logic [ADDR_W-1:0]               rf_addr_o,
  input  logic [DATA_W-1:0]               rf_data_i,
  output logic [ADDR_W-1:0]               exp_addr_o,
  input  logic [DATA_W-1:0]               exp_data_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            pass_o,
  output logic [ADDR_W:0]                 err_count_o,
  output logic [ADDR_W-1:0]               first_fail_o,
  output logic                            fail_seen_o,
  output logic                            trace_valid_o,
  input  logic                            trace_ready_i,
  output logic [CYC_W+ADDR_W+DATA_W-1:0]  trace_data_o,
  output logic                            trace_ovf_o
);

  localparam int PW    = $clog2(TRACE_DEPTH);
  localparam int ENT_W = CYC_W + ADDR_W + DATA_W;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_SCAN, S_DRAIN, S_DONE} state_t;

  state_t              state_q;
  logic [CYC_W-1:0]    cnt_q;
  logic [CYC_W-1:0]    stamp_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [ADDR_W-1:0]   cmp_idx_q;
  logic                cmp_vld_q;
  logic [DATA_W-1:0]   rf_data_q;
  logic [ADDR_W:0]     err_cnt_q;
  logic [ADDR_W-1:0]   first_fail_q;
  logic                fail_seen_q;

  logic [PW:0]         wr_ptr_q, rd_ptr_q;
  logic                ovf_q;
  logic [ENT_W-1:0]    mem_q [TRACE_DEPTH];

  logic start_acc, push_req, push, pop, empty, full, mismatch;

  assign start_acc = start_i && !abort_i && (state_q == S_IDLE || state_q == S_DONE);
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign push_req  = (state_q == S_RUN) && wr_en_i && (wr_reg_i != '0);
  assign pop       = !empty && trace_ready_i;
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign push      = push_req && (!full || pop);
  assign mismatch  = cmp_vld_q && (rf_data_q != exp_data_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      stamp_q      <= '0;
      idx_q        <= '0;
      cmp_idx_q    <= '0;
      cmp_vld_q    <= 1'b0;
      rf_data_q    <= '0;
      err_cnt_q    <= '0;
      first_fail_q <= '0;
      fail_seen_q  <= 1'b0;
    end else begin
      cmp_vld_q <= 1'b0;
      if (abort_i) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (start_i) begin
              err_cnt_q    <= '0;
              fail_seen_q  <= 1'b0;
              first_fail_q <= '0;
              stamp_q      <= '0;
              idx_q        <= '0;
              cnt_q        <= num_cycles_i;
              state_q      <= (num_cycles_i == '0) ? S_SCAN : S_RUN;
            end
          end
          S_RUN: begin
            stamp_q <= stamp_q + 1'b1;
            cnt_q   <= cnt_q - 1'b1;
            if (cnt_q == CYC_W'(1)) state_q <= S_SCAN;
          end
          S_SCAN: begin
            // Register port-A data so it lines up with the ROM's one-cycle latency.
            rf_data_q <= rf_data_i;
            cmp_idx_q <= idx_q;
            cmp_vld_q <= 1'b1;
            if (idx_q == ADDR_W'(NUM_REGS - 1)) state_q <= S_DRAIN;
            else idx_q <= idx_q + 1'b1;
          end
          S_DRAIN: state_q <= S_DONE;
          default: state_q <= S_IDLE;
        endcase
        if (mismatch) begin
          if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
          if (!fail_seen_q) begin
            fail_seen_q  <= 1'b1;
            first_fail_q <= cmp_idx_q;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else if (start_acc) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_req && !push) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !start_acc) mem_q[wr_ptr_q[PW-1:0]] <= {stamp_q, wr_reg_i, wr_data_i};
  end

  assign test_mode_o   = (state_q == S_SCAN) || (state_q == S_DRAIN);
  assign busy_o        = (state_q == S_RUN) || test_mode_o;
  assign done_o        = (state_q == S_DONE);
  assign pass_o        = done_o && (err_cnt_q == '0);
  assign rf_addr_o     = idx_q;
  assign exp_addr_o    = idx_q;
  assign err_count_o   = err_cnt_q;
  assign first_fail_o  = first_fail_q;
  assign fail_seen_o   = fail_seen_q;
  assign trace_valid_o = !empty;
  assign trace_data_o  = empty ? '0 : mem_q[rd_ptr_q[PW-1:0]];
  assign trace_ovf_o   = ovf_q;

endmodule

// File: tb/tb_regfile_scan_checker.sv
// Scoreboard bench for regfile_scan_checker: drivers push expected trace entries and
// run results into queues; negedge monitors pop and compare as the DUT presents them.
module tb_regfile_scan_checker;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int TD = 16;
  localparam int EW = CW + AW + DW;

  typedef struct {
    int err;
    int first;
    bit seen;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start, abort, wr_en, trace_ready;
  logic [CW-1:0] num_cycles;
  logic [AW-1:0] wr_reg;
  logic [DW-1:0] wr_data;
  logic test_mode, busy, done, pass, fail_seen, trace_valid, trace_ovf;
  logic [AW-1:0] rf_addr, exp_addr, first_fail;
  logic [DW-1:0] rf_data, exp_data;
  logic [AW:0] err_count;
  logic [EW-1:0] trace_data;

  logic [DW-1:0] rf_mem [NR];
  logic [DW-1:0] exp_rom [NR];

  int checks = 0;
  int errors = 0;
  int pops = 0;
  logic [EW-1:0] tq[$];
  res_t rq[$];
  bit m_ovf;

  bit            plan_en   [64];
  logic [AW-1:0] plan_reg  [64];
  logic [DW-1:0] plan_data [64];
  bit            plan_rdy  [64];

  always #5 clk = ~clk;

  // Environment: CPU regfile with combinational port A, ROM with one-cycle latency.
  assign rf_data = rf_mem[rf_addr];
  always @(posedge clk) begin
    if (wr_en) rf_mem[wr_reg] <= wr_data;
    exp_data <= exp_rom[exp_addr];
  end

  regfile_scan_checker #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .CYC_W(CW), .TRACE_DEPTH(TD)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort), .num_cycles_i(num_cycles),
    .wr_en_i(wr_en), .wr_reg_i(wr_reg), .wr_data_i(wr_data), .test_mode_o(test_mode),
    .rf_addr_o(rf_addr), .rf_data_i(rf_data), .exp_addr_o(exp_addr), .exp_data_i(exp_data),
    .busy_o(busy), .done_o(done), .pass_o(pass), .err_count_o(err_count),
    .first_fail_o(first_fail), .fail_seen_o(fail_seen), .trace_valid_o(trace_valid),
    .trace_ready_i(trace_ready), .trace_data_o(trace_data), .trace_ovf_o(trace_ovf)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Trace and result monitors.
  initial begin
    logic done_prev;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (trace_valid && trace_ready) begin
        pops++;
        if (tq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL trace_extra: got 0x%0h, expected no entry", trace_data);
        end else begin
          check("trace_data", 64'(trace_data), 64'(tq[0]));
          void'(tq.pop_front());
        end
      end
      if (done && !done_prev) begin
        if (rq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1, expected no run pending");
        end else begin
          check("err_count", 64'(err_count), 64'(rq[0].err));
          check("fail_seen", 64'(fail_seen), 64'(rq[0].seen));
          if (rq[0].seen) check("first_fail", 64'(first_fail), 64'(rq[0].first));
          check("pass", 64'(pass), 64'(rq[0].err == 0));
          void'(rq.pop_front());
        end
      end
      done_prev = done;
    end
  end

  task automatic clear_plan();
    for (int i = 0; i < 64; i++) begin
      plan_en[i] = 1'b0; plan_reg[i] = '0; plan_data[i] = '0; plan_rdy[i] = 1'b0;
    end
  endtask

  task automatic rand_plan(input int n, input int rdy_pct);
    clear_plan();
    for (int i = 0; i < n; i++) begin
      plan_en[i]   = ($urandom_range(0, 99) < 60);
      plan_reg[i]  = AW'($urandom_range(0, NR - 1));
      plan_data[i] = $urandom;
      plan_rdy[i]  = ($urandom_range(0, 99) < rdy_pct);
    end
  endtask

  task automatic do_run(input int n, input logic [NR-1:0] mis);
    logic [DW-1:0] fin [NR];
    res_t r;
    int k;
    for (int i = 0; i < NR; i++) fin[i] = rf_mem[i];
    for (int i = 0; i < n; i++) if (plan_en[i]) fin[plan_reg[i]] = plan_data[i];
    r.err = 0; r.first = 0; r.seen = 1'b0;
    for (int i = NR - 1; i >= 0; i--) begin
      exp_rom[i] = fin[i] ^ (mis[i] ? 32'h8000_0001 : 32'h0);
      if (mis[i]) begin r.err++; r.first = i; r.seen = 1'b1; end
    end
    rq.push_back(r);
    tq.delete();
    m_ovf = 1'b0;
    num_cycles = CW'(n); start = 1'b1; trace_ready = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      wr_en = plan_en[i]; wr_reg = plan_reg[i]; wr_data = plan_data[i]; trace_ready = plan_rdy[i];
      if (plan_en[i] && plan_reg[i] != '0) begin
        if (tq.size() < TD || (plan_rdy[i] && tq.size() > 0))
          tq.push_back({CW'(i), plan_reg[i], plan_data[i]});
        else
          m_ovf = 1'b1;
      end
      tick();
    end
    wr_en = 1'b0; trace_ready = 1'b0;
    check("test_mode_scan", 64'(test_mode), 64'(1));
    k = 0;
    while (!done && k < 200) begin tick(); k++; end
    check("scan_len", 64'(k), 64'(NR + 1));
    check("test_mode_done", 64'(test_mode), 64'(0));
    check("trace_ovf", 64'(trace_ovf), 64'(m_ovf));
  endtask

  task automatic drain();
    int exp_n, k;
    exp_n = tq.size();
    pops = 0;
    trace_ready = 1'b1;
    k = 0;
    while (trace_valid && k < 64) begin tick(); k++; end
    trace_ready = 1'b0;
    check("drain_count", 64'(pops), 64'(exp_n));
    check("trace_empty", 64'(trace_valid), 64'(0));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; wr_en = 1'b0; trace_ready = 1'b0;
    num_cycles = '0; wr_reg = '0; wr_data = '0;
    for (int i = 0; i < NR; i++) exp_rom[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_flags", 64'({test_mode, busy, done, pass, fail_seen, trace_valid, trace_ovf}), 64'(0));
    check("reset_counts", 64'({err_count, first_fail, rf_addr}), 64'(0));
    check("reset_trace", 64'(trace_data), 64'(0));
    rst_n = 1'b1;
    tick();

    // Load the CPU regfile while the checker idles; nothing is traced outside RUN.
    for (int i = 0; i < NR; i++) begin
      wr_en = 1'b1; wr_reg = AW'(i); wr_data = $urandom;
      tick();
    end
    wr_en = 1'b0;
    tick();
    check("idle_no_trace", 64'(trace_valid), 64'(0));

    // r3=7 at stamp 1 is logged, r0 at stamp 2 is not; ROM matches -> pass.
    clear_plan();
    plan_en[1] = 1'b1; plan_reg[1] = 5'd3; plan_data[1] = 32'd7;
    plan_en[2] = 1'b1; plan_reg[2] = 5'd0; plan_data[2] = 32'd9;
    do_run(5, '0);
    check("t1_head", 64'(trace_data), 64'({16'd1, 5'd3, 32'd7}));
    check("t2_pass", 64'(pass), 64'(1));
    drain();
    check("t1_one_entry", 64'(pops), 64'(1));

    // Mismatches at r4 and r17.
    rand_plan(8, 50);
    do_run(8, (32'h1 << 4) | (32'h1 << 17));
    check("t3_err", 64'({err_count, first_fail, fail_seen, pass}), 64'({6'd2, 5'd4, 1'b1, 1'b0}));
    drain();

    // 20 logged writes with no pops, then push+pop while full.
    clear_plan();
    for (int i = 0; i < 21; i++) begin
      plan_en[i] = 1'b1; plan_reg[i] = AW'((i % (NR - 1)) + 1); plan_data[i] = $urandom;
    end
    plan_rdy[20] = 1'b1;
    do_run(22, '0);
    check("t4_ovf", 64'(trace_ovf), 64'(1));
    drain();
    check("t4_count", 64'(pops), 64'(TD));

    // Zero-length run, ignored start during SCAN, abort mid-SCAN.
    num_cycles = '0; start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_scan_now", 64'({test_mode, busy, rf_addr}), 64'({1'b1, 1'b1, 5'd0}));
    tick(); tick();
    start = 1'b1; num_cycles = 16'd5;
    tick();
    start = 1'b0;
    check("t5_start_ignored", 64'({test_mode, rf_addr}), 64'({1'b1, 5'd3}));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_abort", 64'({test_mode, busy, done}), 64'(0));
    tick();
    check("t5_stay_idle", 64'({test_mode, busy, done}), 64'(0));

    // Asynchronous reset in the middle of RUN.
    tq.delete();
    num_cycles = 16'd10; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_reg = AW'(i + 1); wr_data = $urandom;
      tick();
    end
    wr_en = 1'b0;
    check("t6_pre_busy", 64'({busy, trace_valid}), 64'({1'b1, 1'b1}));
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_flags", 64'({test_mode, busy, done, pass, fail_seen, trace_valid, trace_ovf}), 64'(0));
    check("t6_async_counts", 64'({err_count, first_fail, rf_addr}), 64'(0));
    tick(); tick();
    rst_n = 1'b1;
    tick();

    for (int t = 0; t < 6; t++) begin
      int n;
      n = $urandom_range(0, 40);
      rand_plan(n, $urandom_range(0, 100));
      do_run(n, NR'($urandom & $urandom & $urandom));
      drain();
    end

    check("results_consumed", 64'(rq.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
